// File: rtl/lu_pkg.sv
// Shared types for the lu engine and its sequencer.
// Holds the scheduler state encoding, complex element type and constant 1+0i.
package lu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } sched_state_t;

    typedef logic [127:0] cplx_t;

    localparam cplx_t ONE_C = {64'b0, 64'h3ff0000000000000};

endpackage

// File: rtl/lu_res_fifo.sv
// Two-entry FIFO with a registered head, for lu result pairs.
// Ports: clk_i, rst_ni, clr_i, push_i, pop_i, din_i, dout_o, full_o, empty_o.
module lu_res_fifo #(
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [DW-1:0] din_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] slot1;
    logic [1:0]    cnt;
    logic          do_pop;
    logic          do_push;

    assign full_o  = (cnt == 2'd2);
    assign empty_o = (cnt == 2'd0);
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dout_o <= '0;
            slot1  <= '0;
            cnt    <= 2'd0;
        end else if (clr_i) begin
            cnt <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (cnt == 2'd0) dout_o <= din_i;
                    else             slot1  <= din_i;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    dout_o <= slot1;
                    cnt    <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        dout_o <= din_i;
                    end else begin
                        dout_o <= slot1;
                        slot1  <= din_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/lu_sched.sv
// Sequencer and row store for the lu engine: loads a matrix, launches lu,
// serves its row reads/write-backs and queues its results downstream.
// Ports: host load (load_*), lu control (lu_*), lu reads (rd_*), lu
// write-backs (wb_*), lu results (res_*), downstream (out_*), status.
module lu_sched
    import lu_pkg::*;
#(
    parameter int SIZE = 16,
    localparam int AW = $clog2(SIZE),
    localparam int RW = SIZE * 128
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          flush_i,
    output logic          busy_o,
    output logic          done_o,
    input  logic [RW-1:0] load_row_i,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    output logic          lu_start_o,
    output logic          lu_flush_o,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_row_addr_o,
    output logic          rd_row_valid_o,
    input  logic [RW-1:0] wb_row_i,
    input  logic [AW-1:0] wb_addr_i,
    input  logic          wb_valid_i,
    output logic          wb_ready_o,
    input  logic [RW-1:0] res_l_col_i,
    input  logic [RW-1:0] res_u_row_i,
    input  logic [AW-1:0] res_addr_i,
    input  logic          res_valid_i,
    output logic          res_ready_o,
    output logic [RW-1:0] out_l_col_o,
    output logic [RW-1:0] out_u_row_o,
    output logic [AW-1:0] out_addr_o,
    output logic          out_valid_o,
    input  logic          out_ready_i
);

    localparam int FW = 2 * RW + AW;

    sched_state_t  state;
    logic [AW-1:0] load_cnt;
    logic [AW:0]   res_cnt;
    logic [RW-1:0] mem [SIZE];

    logic          run;
    logic          load_fire;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [RW-1:0] mem_wdata;
    logic          fifo_clr;
    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_dout;

    assign run          = (state == RUN);
    assign busy_o       = (state != IDLE);
    assign load_ready_o = (state == LOAD);
    assign wb_ready_o   = run;
    assign lu_flush_o   = flush_i & run;
    assign load_fire    = load_ready_o & load_valid_i & ~flush_i;

    assign res_ready_o = run & (~fifo_full | out_ready_i);
    assign fifo_push   = res_valid_i & res_ready_o & ~flush_i;
    assign fifo_pop    = out_valid_o & out_ready_i & ~flush_i;
    assign fifo_clr    = flush_i | ((state == IDLE) & start_i);

    assign out_valid_o = ~fifo_empty;
    assign {out_l_col_o, out_u_row_o, out_addr_o} = fifo_dout;

    // Single write port: host rows while loading, lu write-backs while running.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = load_cnt;
        mem_wdata = load_row_i;
        if (run) begin
            mem_we    = wb_valid_i & ~flush_i;
            mem_waddr = wb_addr_i;
            mem_wdata = wb_row_i;
        end else begin
            mem_we = load_fire;
        end
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Read port; a same-address write-back in the same cycle wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_row_o       <= '0;
            rd_row_addr_o  <= '0;
            rd_row_valid_o <= 1'b0;
        end else begin
            rd_row_valid_o <= run & rd_addr_valid_i & ~flush_i;
            if (run && rd_addr_valid_i && !flush_i) begin
                rd_row_addr_o <= rd_addr_i;
                if (wb_valid_i && wb_addr_i == rd_addr_i) rd_row_o <= wb_row_i;
                else                                      rd_row_o <= mem[rd_addr_i];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            load_cnt   <= '0;
            res_cnt    <= '0;
            lu_start_o <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            lu_start_o <= 1'b0;
            done_o     <= 1'b0;
            if (flush_i) begin
                state    <= IDLE;
                load_cnt <= '0;
                res_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            state    <= LOAD;
                            load_cnt <= '0;
                            res_cnt  <= '0;
                        end
                    end
                    LOAD: begin
                        if (load_fire) begin
                            load_cnt <= load_cnt + 1'b1;
                            if (load_cnt == AW'(SIZE - 1)) begin
                                state      <= RUN;
                                lu_start_o <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (fifo_pop) begin
                            res_cnt <= res_cnt + 1'b1;
                            if (res_cnt == (AW + 1)'(SIZE - 1)) begin
                                state  <= DONE;
                                done_o <= 1'b1;
                            end
                        end
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    lu_res_fifo #(
        .DW (FW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   ({res_l_col_i, res_u_row_i, res_addr_i}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule
